rs485_loop_check: RTL and testbench

Loopback checker that sits directly downstream of the RS485 test-pattern shifter. It samples the bits the shifter drives onto the RS485/SPI test lines, along with the bits returned on the paired receive lines. It aligns the two streams by a programmable line delay, compares them bit-by-bit over one 32-bit shift window, and reports a per-channel mismatch count, the first failing bit index, and a pass flag. Software reads the results through the existing register block; no shift-register post-processing is needed.

---
 rtl/rs485_pkg.sv | 20 ++
 rtl/rs485_chan_cmp.sv | 60 ++++++
 rtl/rs485_loop_check.sv | 118 +++++++++++
 tb/tb_rs485_loop_check.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs485_pkg.sv
// Shared types and constants for the RS485 loopback checker.
package rs485_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAlign,
    StCompare,
    StDone
  } state_e;

  localparam int unsigned ERR_W = 6;
  localparam logic [ERR_W-1:0] FIRST_NONE = 6'h3F;
  localparam int unsigned NBITS_DEF = 32;

  // OPB word addresses of the result registers
  localparam logic [4:0] ADDR_STATUS    = 5'h18;
  localparam logic [4:0] ADDR_ERR_CNT   = 5'h19;
  localparam logic [4:0] ADDR_FIRST_ERR = 5'h1A;

endpackage

// File: rtl/rs485_chan_cmp.sv
// One channel of the loopback checker: TX history, delay tap, mismatch count
// and first failing bit index.
module rs485_chan_cmp
  import rs485_pkg::*;
#(
  parameter int unsigned DLY_W = 4
) (
  input  logic             DATACLK,
  input  logic             OPB_RST,
  input  logic             tx_bit,
  input  logic             rx_bit,
  input  logic [DLY_W-1:0] dly,
  input  logic             compare_en,
  input  logic             clear,
  input  logic [ERR_W-1:0] bit_idx,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] first_err
);

  localparam int unsigned HD = 2 ** DLY_W;

  // taps[d] is TX delayed by d cycles; taps[0] is the current sample
  logic [HD-2:0] hist_q;
  logic [HD-1:0] taps;
  logic          mismatch;
  logic [ERR_W-1:0] err_cnt_q;
  logic [ERR_W-1:0] first_err_q;

  assign taps     = {hist_q, tx_bit};
  assign mismatch = rx_bit ^ taps[dly];

  // Free-running TX history, independent of checker state
  always_ff @(posedge DATACLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      hist_q <= '0;
    end else begin
      hist_q <= taps[HD-2:0];
    end
  end

  // Mismatch count and first failing index, cleared at the start of a check
  always_ff @(posedge DATACLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      err_cnt_q   <= '0;
      first_err_q <= FIRST_NONE;
    end else if (clear) begin
      err_cnt_q   <= '0;
      first_err_q <= FIRST_NONE;
    end else if (compare_en && mismatch) begin
      err_cnt_q <= err_cnt_q + ERR_W'(1);
      if (first_err_q == FIRST_NONE) begin
        first_err_q <= bit_idx;
      end
    end
  end

  assign err_cnt   = err_cnt_q;
  assign first_err = first_err_q;

endmodule

// File: rtl/rs485_loop_check.sv
// RS485 loopback checker: aligns returned RX bits against delayed TX bits
// and compares one NBITS-long window per ARM rising edge.
module rs485_loop_check
  import rs485_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned NBITS = NBITS_DEF,
  parameter int unsigned DLY_W = 4
) (
  input  logic               DATACLK,
  input  logic               OPB_RST,
  input  logic               ARM,
  input  logic [DLY_W-1:0]   DELAY,
  input  logic [NCH-1:0]     TX_BIT,
  input  logic [NCH-1:0]     RX_BIT,
  output logic               BUSY,
  output logic               DONE,
  output logic               ABORT,
  output logic [NCH-1:0]     PASS,
  output logic [NCH*6-1:0]   ERR_CNT,
  output logic [NCH*6-1:0]   FIRST_ERR
);

  state_e           state_q;
  logic             arm_q;
  logic [DLY_W-1:0] dly_q;
  logic [DLY_W-1:0] align_q;
  logic [ERR_W-1:0] bit_idx_q;
  logic             abort_q;
  logic             rise;
  logic             clear;
  logic             compare_en;
  logic [NCH-1:0]   chan_zero;

  assign rise       = ARM & ~arm_q;
  assign clear      = rise && (state_q == StIdle);
  // ARM low in COMPARE aborts, so that cycle's bit is not counted
  assign compare_en = (state_q == StCompare) && ARM;

  // Checker FSM with edge detect, delay latch, align and bit counters
  always_ff @(posedge DATACLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      state_q   <= StIdle;
      arm_q     <= 1'b0;
      dly_q     <= '0;
      align_q   <= '0;
      bit_idx_q <= '0;
      abort_q   <= 1'b0;
    end else begin
      arm_q <= ARM;
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            dly_q     <= DELAY;
            align_q   <= DELAY - DLY_W'(1);
            bit_idx_q <= '0;
            abort_q   <= 1'b0;
            state_q   <= (DELAY == '0) ? StCompare : StAlign;
          end
        end
        StAlign: begin
          if (!ARM) begin
            abort_q <= 1'b1;
            state_q <= StIdle;
          end else if (align_q == '0) begin
            state_q <= StCompare;
          end else begin
            align_q <= align_q - DLY_W'(1);
          end
        end
        StCompare: begin
          if (!ARM) begin
            abort_q <= 1'b1;
            state_q <= StIdle;
          end else begin
            bit_idx_q <= bit_idx_q + ERR_W'(1);
            if (bit_idx_q == ERR_W'(NBITS - 1)) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          if (!ARM) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    rs485_chan_cmp #(
      .DLY_W(DLY_W)
    ) u_chan (
      .DATACLK   (DATACLK),
      .OPB_RST   (OPB_RST),
      .tx_bit    (TX_BIT[k]),
      .rx_bit    (RX_BIT[k]),
      .dly       (dly_q),
      .compare_en(compare_en),
      .clear     (clear),
      .bit_idx   (bit_idx_q),
      .err_cnt   (ERR_CNT[6*k +: 6]),
      .first_err (FIRST_ERR[6*k +: 6])
    );
    assign chan_zero[k] = (ERR_CNT[6*k +: 6] == '0);
  end

  // Status decode from registered state
  always_comb begin
    BUSY  = (state_q == StAlign) || (state_q == StCompare);
    DONE  = (state_q == StDone);
    ABORT = abort_q;
    PASS  = DONE ? chan_zero : '0;
  end

endmodule

// File: tb/tb_rs485_loop_check.sv
// Randomised self-checking bench for rs485_loop_check with a log-based model.
module tb_rs485_loop_check;

  localparam int NCH   = 4;
  localparam int NBITS = 32;
  localparam int DLY_W = 4;
  localparam int LOGN  = 1024;

  logic               DATACLK = 1'b0;
  logic               OPB_RST = 1'b1;
  logic               ARM = 1'b0;
  logic [DLY_W-1:0]   DELAY = '0;
  logic [NCH-1:0]     TX_BIT = '0;
  logic [NCH-1:0]     RX_BIT = '0;
  logic               BUSY;
  logic               DONE;
  logic               ABORT;
  logic [NCH-1:0]     PASS;
  logic [NCH*6-1:0]   ERR_CNT;
  logic [NCH*6-1:0]   FIRST_ERR;

  int nvec = 0;
  int nerr = 0;

  rs485_loop_check #(
    .NCH  (NCH),
    .NBITS(NBITS),
    .DLY_W(DLY_W)
  ) dut (
    .DATACLK  (DATACLK),
    .OPB_RST  (OPB_RST),
    .ARM      (ARM),
    .DELAY    (DELAY),
    .TX_BIT   (TX_BIT),
    .RX_BIT   (RX_BIT),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ABORT    (ABORT),
    .PASS     (PASS),
    .ERR_CNT  (ERR_CNT),
    .FIRST_ERR(FIRST_ERR)
  );

  always #6 DATACLK = ~DATACLK;

  // Log of what the DUT sampled at each rising edge
  int cyc = 0;
  logic [NCH-1:0] tx_log [LOGN];
  logic [NCH-1:0] rx_log [LOGN];
  always @(posedge DATACLK) begin
    tx_log[cyc % LOGN] <= TX_BIT;
    rx_log[cyc % LOGN] <= RX_BIT;
    cyc <= cyc + 1;
  end

  // Line emulation: random TX, RX returned after rx_dly cycles with faults
  logic [NCH-1:0] txh [16];
  int             rx_dly = 0;
  logic [NCH-1:0] inv_mask = '0;
  logic [NCH-1:0] flip_mask = '0;
  int             flip_cyc = -1;
  bit             rand_rx = 1'b0;
  initial for (int i = 0; i < 16; i++) txh[i] = '0;
  always @(negedge DATACLK) begin
    logic [NCH-1:0] r;
    for (int i = 15; i > 0; i--) txh[i] = txh[i-1];
    txh[0] = NCH'($urandom);
    TX_BIT = txh[0];
    r = rand_rx ? NCH'($urandom) : (txh[rx_dly] ^ inv_mask);
    if (cyc == flip_cyc) r = r ^ flip_mask;
    RX_BIT = r;
  end

  // Expected results of the first ncmp compares of a check armed at edge e0
  function automatic void model(input int e0, input int d, input int ncmp,
                                output logic [NCH*6-1:0] cnt,
                                output logic [NCH*6-1:0] first,
                                output logic [NCH-1:0] pass);
    int c [NCH];
    int f [NCH];
    for (int k = 0; k < NCH; k++) begin
      c[k] = 0;
      f[k] = 63;
    end
    for (int i = 0; i < ncmp; i++) begin
      int e;
      logic [NCH-1:0] rx, tx;
      e  = e0 + d + 1 + i;
      rx = rx_log[e % LOGN];
      tx = tx_log[(e - d) % LOGN];
      for (int k = 0; k < NCH; k++) begin
        if (rx[k] != tx[k]) begin
          c[k]++;
          if (f[k] == 63) f[k] = i;
        end
      end
    end
    for (int k = 0; k < NCH; k++) begin
      cnt[6*k +: 6]   = 6'(c[k]);
      first[6*k +: 6] = 6'(f[k]);
      pass[k]         = (c[k] == 0);
    end
  endfunction

  // Arm a check; report edge index of the rise, status after that edge, and
  // the number of edges after the rise until DONE (-1 if never / aborted)
  task automatic arm_and_run(input int d, input int abort_at,
                             input logic [NCH-1:0] fmask, input int fidx,
                             output int e0, output logic busy0,
                             output logic abort0, output logic [NCH*6-1:0] cnt0,
                             output int done_n);
    @(negedge DATACLK);
    DELAY     = DLY_W'(d);
    ARM       = 1'b1;
    e0        = cyc;
    flip_mask = fmask;
    flip_cyc  = (fidx >= 0) ? e0 + d + 1 + fidx : -1;
    @(posedge DATACLK);
    #1;
    busy0  = BUSY;
    abort0 = ABORT;
    cnt0   = ERR_CNT;
    done_n = -1;
    for (int n = 1; n <= d + NBITS + 8; n++) begin
      @(negedge DATACLK);
      DELAY = DLY_W'($urandom);
      if (abort_at >= 0 && n == d + 1 + abort_at) begin
        ARM = 1'b0;
        @(posedge DATACLK);
        #1;
        break;
      end
      @(posedge DATACLK);
      #1;
      if (DONE) begin
        done_n = n;
        break;
      end
    end
  endtask

  task automatic disarm();
    @(negedge DATACLK);
    ARM = 1'b0;
    @(posedge DATACLK);
    #1;
  endtask

  // Full-window check against the model; name identifies the scenario
  logic [NCH*6-1:0] ec, ef;
  logic [NCH-1:0]   ep;

  task automatic test_reset();
    #20;
    nvec++; if (BUSY !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", BUSY); end
    nvec++; if (DONE !== 1'b0) begin nerr++; $display("FAIL reset_done got %b want 0", DONE); end
    nvec++; if (ABORT !== 1'b0) begin nerr++; $display("FAIL reset_abort got %b want 0", ABORT); end
    nvec++; if (PASS !== 4'h0) begin nerr++; $display("FAIL reset_pass got %h want 0", PASS); end
    nvec++; if (ERR_CNT !== 24'h0) begin nerr++; $display("FAIL reset_errcnt got %h want 0", ERR_CNT); end
    nvec++; if (FIRST_ERR !== {4{6'h3F}}) begin nerr++; $display("FAIL reset_first got %h want %h", FIRST_ERR, {4{6'h3F}}); end
    @(negedge DATACLK);
    OPB_RST = 1'b0;
    repeat (20) @(posedge DATACLK);
  endtask

  task automatic test_matched(input string name, input int d);
    int e0, dn; logic b0, a0; logic [NCH*6-1:0] c0;
    rx_dly = d; inv_mask = '0; rand_rx = 1'b0;
    repeat (20) @(posedge DATACLK);
    arm_and_run(d, -1, '0, -1, e0, b0, a0, c0, dn);
    model(e0, d, NBITS, ec, ef, ep);
    nvec++; if (b0 !== 1'b1) begin nerr++; $display("FAIL %s busy_c1 got %b want 1", name, b0); end
    nvec++; if (dn !== d + NBITS) begin nerr++; $display("FAIL %s done_cycle got %0d want %0d", name, dn + 1, d + NBITS + 1); end
    nvec++; if (BUSY !== 1'b0) begin nerr++; $display("FAIL %s busy_done got %b want 0", name, BUSY); end
    nvec++; if (ERR_CNT !== 24'h0) begin nerr++; $display("FAIL %s errcnt got %h want 0", name, ERR_CNT); end
    nvec++; if (FIRST_ERR !== {4{6'h3F}}) begin nerr++; $display("FAIL %s first got %h want %h", name, FIRST_ERR, {4{6'h3F}}); end
    nvec++; if (PASS !== 4'hF) begin nerr++; $display("FAIL %s pass got %h want F", name, PASS); end
    nvec++; if (ec !== 24'h0) begin nerr++; $display("FAIL %s model_sanity got %h want 0", name, ec); end
    disarm();
    nvec++; if (DONE !== 1'b0 || ERR_CNT !== 24'h0) begin nerr++; $display("FAIL %s disarm done=%b errcnt=%h want 0/0", name, DONE, ERR_CNT); end
  endtask

  task automatic test_misaligned();
    int e0, dn; logic b0, a0; logic [NCH*6-1:0] c0;
    for (int t = 0; t < 6; t++) begin
      int d;
      d = (t == 0) ? 2 : int'($urandom_range(0, 15));
      rx_dly = (t == 0) ? 3 : int'($urandom_range(0, 15));
      inv_mask = '0; rand_rx = 1'b0;
      repeat (18) @(posedge DATACLK);
      arm_and_run(d, -1, '0, -1, e0, b0, a0, c0, dn);
      model(e0, d, NBITS, ec, ef, ep);
      nvec++; if (dn !== d + NBITS) begin nerr++; $display("FAIL misalign%0d done_cycle got %0d want %0d", t, dn + 1, d + NBITS + 1); end
      nvec++; if (ERR_CNT !== ec) begin nerr++; $display("FAIL misalign%0d errcnt got %h want %h", t, ERR_CNT, ec); end
      nvec++; if (FIRST_ERR !== ef) begin nerr++; $display("FAIL misalign%0d first got %h want %h", t, FIRST_ERR, ef); end
      nvec++; if (PASS !== ep) begin nerr++; $display("FAIL misalign%0d pass got %h want %h", t, PASS, ep); end
      disarm();
    end
  endtask

  task automatic test_invert();
    int e0, dn; logic b0, a0; logic [NCH*6-1:0] c0;
    rx_dly = 0; inv_mask = 4'b0100; rand_rx = 1'b0;
    repeat (18) @(posedge DATACLK);
    arm_and_run(0, -1, '0, -1, e0, b0, a0, c0, dn);
    nvec++; if (ERR_CNT[17:12] !== 6'd32) begin nerr++; $display("FAIL invert_cnt2 got %0d want 32", ERR_CNT[17:12]); end
    nvec++; if (FIRST_ERR[17:12] !== 6'd0) begin nerr++; $display("FAIL invert_first2 got %0d want 0", FIRST_ERR[17:12]); end
    nvec++; if (PASS !== 4'b1011) begin nerr++; $display("FAIL invert_pass got %b want 1011", PASS); end
    disarm();
    inv_mask = '0;
  endtask

  task automatic test_single_flip();
    int e0, dn; logic b0, a0; logic [NCH*6-1:0] c0;
    rx_dly = 5; inv_mask = '0; rand_rx = 1'b0;
    repeat (18) @(posedge DATACLK);
    arm_and_run(5, -1, 4'b0010, 17, e0, b0, a0, c0, dn);
    nvec++; if (ERR_CNT[11:6] !== 6'd1) begin nerr++; $display("FAIL flip_cnt1 got %0d want 1", ERR_CNT[11:6]); end
    nvec++; if (FIRST_ERR[11:6] !== 6'd17) begin nerr++; $display("FAIL flip_first1 got %0d want 17", FIRST_ERR[11:6]); end
    nvec++; if (PASS !== 4'b1101) begin nerr++; $display("FAIL flip_pass got %b want 1101", PASS); end
    disarm();
    flip_mask = '0; flip_cyc = -1;
  endtask

  task automatic test_abort_rearm();
    int e0, dn; logic b0, a0; logic [NCH*6-1:0] c0;
    rand_rx = 1'b1;
    repeat (5) @(posedge DATACLK);
    arm_and_run(2, 10, '0, -1, e0, b0, a0, c0, dn);
    model(e0, 2, 10, ec, ef, ep);
    nvec++; if (ABORT !== 1'b1) begin nerr++; $display("FAIL abort_flag got %b want 1", ABORT); end
    nvec++; if (DONE !== 1'b0 || BUSY !== 1'b0 || PASS !== 4'h0) begin nerr++; $display("FAIL abort_status done=%b busy=%b pass=%h want 0/0/0", DONE, BUSY, PASS); end
    nvec++; if (ERR_CNT !== ec) begin nerr++; $display("FAIL abort_partial_cnt got %h want %h", ERR_CNT, ec); end
    nvec++; if (FIRST_ERR !== ef) begin nerr++; $display("FAIL abort_partial_first got %h want %h", FIRST_ERR, ef); end
    repeat (3) @(posedge DATACLK);
    arm_and_run(4, -1, '0, -1, e0, b0, a0, c0, dn);
    model(e0, 4, NBITS, ec, ef, ep);
    nvec++; if (a0 !== 1'b0) begin nerr++; $display("FAIL rearm_abort_clr got %b want 0", a0); end
    nvec++; if (c0 !== 24'h0) begin nerr++; $display("FAIL rearm_cnt_clr got %h want 0", c0); end
    nvec++; if (ERR_CNT !== ec || FIRST_ERR !== ef || PASS !== ep) begin nerr++; $display("FAIL rearm_result cnt=%h/%h first=%h/%h pass=%h/%h", ERR_CNT, ec, FIRST_ERR, ef, PASS, ep); end
    disarm();
  endtask

  task automatic test_back_to_back();
    int e0, dn; logic b0, a0; logic [NCH*6-1:0] c0;
    rand_rx = 1'b1;
    for (int t = 0; t < 4; t++) begin
      int d;
      d = int'($urandom_range(0, 15));
      arm_and_run(d, -1, '0, -1, e0, b0, a0, c0, dn);
      model(e0, d, NBITS, ec, ef, ep);
      nvec++; if (dn !== d + NBITS) begin nerr++; $display("FAIL b2b%0d done_cycle got %0d want %0d", t, dn + 1, d + NBITS + 1); end
      nvec++; if (ERR_CNT !== ec || FIRST_ERR !== ef || PASS !== ep) begin nerr++; $display("FAIL b2b%0d result cnt=%h/%h first=%h/%h pass=%h/%h", t, ERR_CNT, ec, FIRST_ERR, ef, PASS, ep); end
      disarm();
    end
  endtask

  task automatic test_mid_reset();
    int seen;
    rand_rx = 1'b1;
    @(negedge DATACLK);
    DELAY = 4'd1;
    ARM   = 1'b1;
    repeat (10) @(posedge DATACLK);
    #3;
    OPB_RST = 1'b1;
    ARM     = 1'b0;
    #1;
    nvec++; if (BUSY !== 1'b0 || DONE !== 1'b0 || ABORT !== 1'b0 || PASS !== 4'h0) begin nerr++; $display("FAIL midrst_status busy=%b done=%b abort=%b pass=%h want 0", BUSY, DONE, ABORT, PASS); end
    nvec++; if (ERR_CNT !== 24'h0 || FIRST_ERR !== {4{6'h3F}}) begin nerr++; $display("FAIL midrst_results cnt=%h first=%h want 0/%h", ERR_CNT, FIRST_ERR, {4{6'h3F}}); end
    @(negedge DATACLK);
    OPB_RST = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge DATACLK);
      #1;
      if (DONE || BUSY) seen++;
    end
    nvec++; if (seen !== 0) begin nerr++; $display("FAIL midrst_no_done got %0d active cycles want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_matched("loop_d0", 0);
    test_matched("loop_d3", 3);
    test_misaligned();
    test_invert();
    test_single_flip();
    test_abort_rearm();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
